// File: rtl/bdc_xfer.sv
// bdc_xfer: single-wire BKGD transfer engine.
// Shifts DATA_W-bit words MSB first in bit cells timed by target-clock ticks.
module bdc_xfer #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int T_ONE_LOW  = 4,
  parameter int T_ZERO_LOW = 14,
  parameter int T_BIT      = 18,
  parameter int T_RX_LOW   = 3,
  parameter int T_SAMPLE   = 10,
  parameter int T_RX_BIT   = 16,
  parameter int ACK_TMO    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgt_clk_pulse,
  input  logic              bkgd_in,
  output logic              bkgd_drive_low,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int TM1  = (T_BIT > T_RX_BIT) ? T_BIT : T_RX_BIT;
  localparam int TMAX = (TM1 > ACK_TMO) ? TM1 : ACK_TMO;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(DATA_W + 1);

  typedef enum logic [3:0] {
    IDLE, TX_LOAD, TX_LOW, TX_HIGH, RX_LOW,
    RX_WAIT, RX_REST, ACK_WAIT, ACK_LOW, DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        sync;
  logic              lvl;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     low_len;
  logic [BW-1:0]     bits;
  logic [LEN_W-1:0]  words;
  logic [DATA_W-1:0] sh;
  logic              ack_en;
  logic              last_bit;
  logic              last_word;
  logic              accept;
  logic              take;
  logic              bit_end;
  logic              sample;
  logic              tmo;

  assign tick      = tgt_clk_pulse;
  assign lvl       = sync[1];
  assign cnt_inc   = cnt + CW'(1);
  assign low_len   = sh[DATA_W-1] ? CW'(T_ONE_LOW) : CW'(T_ZERO_LOW);
  assign last_bit  = (bits == BW'(DATA_W - 1));
  assign last_word = (words == LEN_W'(1));

  assign bkgd_drive_low = (state == TX_LOW) || (state == RX_LOW);
  assign cmd_ready      = (state == IDLE);
  assign tx_ready       = (state == TX_LOAD);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  // two-flop synchroniser; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], bkgd_in};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    take     = 1'b0;
    bit_end  = 1'b0;
    sample   = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0)  state_nx = DONE;
          else if (cmd_dir)   state_nx = RX_LOW;
          else                state_nx = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (tx_valid) begin
          take     = 1'b1;
          state_nx = TX_LOW;
        end
      end
      TX_LOW: begin
        if (tick && cnt_inc == low_len) state_nx = TX_HIGH;
      end
      TX_HIGH: begin
        if (tick && cnt_inc == CW'(T_BIT)) begin
          bit_end = 1'b1;
          if (!last_bit)       state_nx = TX_LOW;
          else if (!last_word) state_nx = TX_LOAD;
          else if (ack_en)     state_nx = ACK_WAIT;
          else                 state_nx = DONE;
        end
      end
      RX_LOW: begin
        if (tick && cnt_inc == CW'(T_RX_LOW)) state_nx = RX_WAIT;
      end
      RX_WAIT: begin
        if (tick && cnt_inc == CW'(T_SAMPLE)) begin
          sample   = 1'b1;
          state_nx = RX_REST;
        end
      end
      RX_REST: begin
        if (tick && cnt_inc == CW'(T_RX_BIT)) begin
          bit_end = 1'b1;
          if (!last_bit || !last_word) state_nx = RX_LOW;
          else if (ack_en)             state_nx = ACK_WAIT;
          else                         state_nx = DONE;
        end
      end
      ACK_WAIT: begin
        if (!lvl) state_nx = ACK_LOW;
        else if (tick && cnt_inc == CW'(ACK_TMO)) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      ACK_LOW: begin
        if (lvl) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tick counter, bit/word counters, shifter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bits     <= '0;
      words    <= '0;
      sh       <= '0;
      ack_en   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept || take || bit_end) cnt <= '0;
      else if (tick)                 cnt <= cnt_inc;
      if (accept) begin
        words   <= cmd_len;
        ack_en  <= cmd_ack;
        bits    <= '0;
        ack_err <= 1'b0;
      end
      if (take) sh <= tx_data;
      if (bit_end) begin
        bits <= last_bit ? '0 : bits + BW'(1);
        if (state == TX_HIGH) sh <= sh << 1;
        if (last_bit) words <= words - LEN_W'(1);
      end
      if (sample) begin
        sh <= {sh[DATA_W-2:0], lvl};
        if (last_bit) begin
          rx_data  <= {sh[DATA_W-2:0], lvl};
          rx_valid <= 1'b1;
        end
      end
      if (tmo) ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bdc_xfer.sv
// tb_bdc_xfer: randomized bench for bdc_xfer.
// Models the bus and target; expectations come from bit-cell rules.
module tb_bdc_xfer;

  localparam int T1  = 4;
  localparam int T0  = 14;
  localparam int TB  = 18;
  localparam int TRL = 3;
  localparam int TRB = 16;
  localparam int TMO = 64;
  localparam int LIM = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tgt_clk_pulse = 1'b0;
  logic       bkgd_in;
  logic       bkgd_drive_low;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_len = '0;
  logic       cmd_ack = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       ack_err;

  int checks = 0;
  int errors = 0;

  bit         tick_all = 1'b1;
  logic       tgt_low = 1'b0;
  bit         prev_drv = 1'b0;
  int         cur_low = 0;
  int         cur_high = 0;
  int         rises = 0;
  int         tail = 0;
  bit         err_at_done = 1'b0;
  int         low_q[$];
  int         high_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] wq[$];
  bit         rx_pat[$];
  int         rx_base = 0;
  bit         rx_mode = 1'b0;
  bit         ack_resp = 1'b0;
  int         ack_at = -1;
  int         aphase = 0;
  int         acnt = 0;
  int         hold = 0;
  bit         holding = 1'b0;

  assign bkgd_in = !(bkgd_drive_low || tgt_low);

  bdc_xfer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tgt_clk_pulse  (tgt_clk_pulse),
    .bkgd_in        (bkgd_in),
    .bkgd_drive_low (bkgd_drive_low),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dir        (cmd_dir),
    .cmd_len        (cmd_len),
    .cmd_ack        (cmd_ack),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .busy           (busy),
    .done           (done),
    .ack_err        (ack_err)
  );

  always #5 clk = ~clk;

  // target-clock strobe: every clk or roughly one in three
  always @(posedge clk) begin
    #1;
    tgt_clk_pulse = tick_all ? 1'b1 : ($urandom_range(0, 2) == 0);
  end

  // bus monitor plus target responder
  always @(negedge clk) begin
    if (bkgd_drive_low) begin
      if (!prev_drv) begin
        high_q.push_back(cur_high);
        cur_low = 0;
        rises++;
        if (rx_mode && (low_q.size() - rx_base) < rx_pat.size()) begin
          if (!rx_pat[low_q.size() - rx_base]) begin
            tgt_low = 1'b1;
            holding = 1'b1;
            hold = 0;
          end
        end
      end
      if (tgt_clk_pulse) cur_low++;
    end else begin
      if (prev_drv) begin
        low_q.push_back(cur_low);
        cur_high = 0;
        if (ack_resp && low_q.size() == ack_at) begin
          aphase = 1;
          acnt = 0;
        end
      end
      if (tgt_clk_pulse && !done) cur_high++;
    end
    if (holding && tgt_clk_pulse) begin
      hold++;
      if (hold >= 13) begin
        tgt_low = 1'b0;
        holding = 1'b0;
      end
    end
    if (aphase != 0 && tgt_clk_pulse) begin
      acnt++;
      if (aphase == 1 && acnt == 20) begin
        tgt_low = 1'b1;
        aphase = 2;
        acnt = 0;
      end else if (aphase == 2 && acnt == 16) begin
        tgt_low = 1'b0;
        aphase = 0;
      end
    end
    if (rx_valid) rx_q.push_back(rx_data);
    if (done) begin
      tail = cur_high;
      err_at_done = ack_err;
    end
    prev_drv = bkgd_drive_low;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input bit dir, input int len, input bit ack);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = dir;
    cmd_len = 4'(len);
    cmd_ack = ack;
    t = 0;
    while (!cmd_ready && t < LIM) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ackclr", ack_err, 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_ready", cmd_ready, 1);
  endtask

  function automatic int exp_low(input int k);
    logic [7:0] w;
    w = wq[k / 8];
    return w[7 - k % 8] ? T1 : T0;
  endfunction

  task automatic run_tx(input bit ack, input bit resp, input bit stall);
    int lb, hb, n, t;
    bit sd;
    lb = low_q.size();
    hb = high_q.size();
    n = wq.size() * 8;
    rx_mode = 1'b0;
    ack_resp = resp;
    ack_at = lb + n;
    do_cmd(1'b0, wq.size(), ack);
    foreach (wq[i]) begin
      if (stall && i > 0) begin
        t = 0;
        while (!tx_ready && t < LIM) begin
          @(negedge clk);
          t++;
        end
        sd = 1'b0;
        repeat (50) begin
          @(negedge clk);
          if (bkgd_drive_low) sd = 1'b1;
        end
        chk("stall_rel", sd, 0);
      end
      tx_valid = 1'b1;
      tx_data = wq[i];
      t = 0;
      while (!tx_ready && t < LIM) begin
        @(negedge clk);
        t++;
      end
      chk("tx_rdy_seen", tx_ready, 1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tx_rdy_fall", tx_ready, 0);
    end
    wait_done();
    chk("tx_nbits", low_q.size() - lb, n);
    if (low_q.size() - lb == n) begin
      for (int k = 0; k < n; k++)
        chk("tx_low", low_q[lb + k], exp_low(k));
      for (int k = 0; k < n - 1; k++)
        if (k % 8 != 7)
          chk("tx_high", high_q[hb + 1 + k], TB - exp_low(k));
      if (!ack)
        chk("tx_tail", tail, TB - exp_low(n - 1));
      else if (!resp)
        chk("ack_tmo_tail", tail, TB - exp_low(n - 1) + TMO);
    end
    chk("ack_err", err_at_done, ack && !resp);
    ack_resp = 1'b0;
  endtask

  task automatic run_rx();
    int lb, hb, rb, n;
    lb = low_q.size();
    hb = high_q.size();
    rb = rx_q.size();
    n = wq.size() * 8;
    rx_pat.delete();
    foreach (wq[i])
      for (int b = 7; b >= 0; b--) rx_pat.push_back(wq[i][b]);
    rx_base = lb;
    rx_mode = 1'b1;
    ack_resp = 1'b0;
    do_cmd(1'b1, wq.size(), 1'b0);
    wait_done();
    rx_mode = 1'b0;
    chk("rx_nwords", rx_q.size() - rb, wq.size());
    if (rx_q.size() - rb == wq.size())
      foreach (wq[i]) chk("rx_word", rx_q[rb + i], wq[i]);
    chk("rx_nbits", low_q.size() - lb, n);
    if (low_q.size() - lb == n) begin
      for (int k = 0; k < n; k++) chk("rx_low", low_q[lb + k], TRL);
      for (int k = 0; k < n - 1; k++)
        chk("rx_period", high_q[hb + 1 + k] + low_q[lb + k], TRB);
      chk("rx_tail", tail, TRB - TRL);
    end
  endtask

  initial begin
    int r0, t;
    repeat (3) @(negedge clk);
    chk("rst_drv", bkgd_drive_low, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_txrdy", tx_ready, 0);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_rxvld", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ackerr", ack_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wq = '{8'hA5};
    run_tx(1'b0, 1'b0, 1'b0);
    wq = '{8'h3C, 8'hFF};
    run_rx();
    wq = '{8'($urandom), 8'($urandom)};
    run_tx(1'b0, 1'b0, 1'b1);
    wq = '{8'($urandom)};
    run_tx(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ack_hold", ack_err, 1);

    r0 = rises;
    do_cmd(1'b0, 0, 1'b0);
    chk("len0_done", done, 1);
    @(negedge clk);
    chk("len0_pulse", done, 0);
    chk("len0_nodrv", rises - r0, 0);

    tick_all = 1'b0;
    for (int it = 0; it < 8; it++) begin
      wq.delete();
      repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) run_rx();
      else run_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    wq = '{8'h00};
    do_cmd(1'b0, 1, 1'b0);
    tx_valid = 1'b1;
    tx_data = 8'h00;
    t = 0;
    while (!bkgd_drive_low && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("mid_low", bkgd_drive_low, 1);
    tx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_drv", bkgd_drive_low, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);

    wq = '{8'($urandom)};
    run_tx(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
